// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, response and ALU-side signal bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int W   = 16,
  parameter int OPW = 5
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_result;
  logic [3:0]     rsp_flags;

  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic [3:0]     alu_flags;

  logic [15:0]    ops_done;

  // Arbiter side: serves the requesters, drives the ALU, produces responses.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, alu_result, alu_flags,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    output alu_op, alu_a, alu_b, ops_done
  );

  // Environment side: requesters, response consumer and the ALU itself.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_result, alu_flags,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  alu_op, alu_a, alu_b, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-requester sequencer for the shared ALU
module alu_arbiter #(
  parameter int W   = 16,
  parameter int OPW = 5
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic           last_grant;
  logic           id;
  logic           grant;
  logic           ready0;
  logic           ready1;
  logic           accept;
  logic [OPW-1:0] grant_op;
  logic [W-1:0]   grant_a;
  logic [W-1:0]   grant_b;
  logic [15:0]    ops_cnt;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.ops_done   = ops_cnt;
  assign accept         = ready0 | ready1;

  // Operand mux follows the arbitration winner.
  assign grant_op = grant ? bus.req1_op : bus.req0_op;
  assign grant_a  = grant ? bus.req1_a  : bus.req0_a;
  assign grant_b  = grant ? bus.req1_b  : bus.req0_b;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Arbitration, ready generation and next-state selection.
  always_comb begin
    next_state = state;
    ready0     = 1'b0;
    ready1     = 1'b0;
    // Under contention the requester not served last wins; otherwise the lone valid one.
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else                                  grant = bus.req1_valid;
    case (state)
      IDLE: begin
        // Ready is gated by rst so an asserted reset suppresses it immediately.
        if ((bus.req0_valid || bus.req1_valid) && !rst) begin
          ready0     = ~grant;
          ready1     = grant;
          next_state = EXEC;
        end
      end
      EXEC:    next_state = RESP;
      RESP:    if (bus.rsp_valid && bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, result capture, response handshake and completion count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant     <= 1'b1;
      id             <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      ops_cnt        <= '0;
    end else begin
      if (accept) begin
        // ALU inputs are registered here and then held until the next accept.
        bus.alu_op <= grant_op;
        bus.alu_a  <= grant_a;
        bus.alu_b  <= grant_b;
        id         <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        bus.rsp_result <= bus.alu_result;
        bus.rsp_flags  <= bus.alu_flags;
        bus.rsp_id     <= id;
        bus.rsp_valid  <= 1'b1;
      end
      if (state == RESP && bus.rsp_valid && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        ops_cnt       <= ops_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 16-bit ALU. It accepts operation requests from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU from registered operands, captures the ALU's combinational result and flags, and returns them on a single tagged response channel. It sits between the instruction/control units and the ALU instance, which is the only path to it.

## Interface
- W, 16, operand/result width; must match the ALU's W
- OPW, 5, ALU opcode width

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  OPW  requester 0 opcode (e.g. 5'b00111 = MUL)
- req0_a, req0_b  in  W  requester 0 signed operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index the response belongs to
- rsp_result  out  W  captured ALU result
- rsp_flags  out  4  captured ALU flags
- alu_op  out  OPW  to ALU alu_op
- alu_a, alu_b  out  W  to ALU operandA/operandB
- alu_result  in  W  from ALU resultAccumulator
- alu_flags  in  4  from ALU flags
- ops_done  out  16  count of completed response handshakes

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester, assert its reqN_ready combinationally and go to EXEC.
  - On that edge, capture op/a/b into alu_op/alu_a/alu_b and the grant index into an id register.
  - With no valid, stay in IDLE.
- Arbitration:
  - A single valid requester wins.
  - If both are valid, the requester not granted last wins.
  - The last-grant register resets to 1, so requester 0 wins the first contention.
- reqN_ready is high only in IDLE, only for the granted index, and only while rst is low. It is never high for both requesters at once.
- EXEC lasts exactly one cycle; ALU inputs are stable throughout. At the end of EXEC:
  - alu_result → rsp_result, alu_flags → rsp_flags, id → rsp_id.
  - rsp_valid is set and the FSM goes to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid, increment ops_done and go to IDLE.
- alu_op/alu_a/alu_b hold their last captured values outside EXEC; they do not return to 0.
- Arithmetic is performed entirely by the ALU. The arbiter does not inspect opcodes or modify data. Width rules are the ALU's (W-bit truncated result).
- A requester may drop valid before ready without effect. A valid held while the other requester is served stays pending and wins the next IDLE arbitration.
- ops_done wraps from 16'hFFFF to 16'h0000.

## Timing
- Reset values (async, immediate): state IDLE, last-grant 1, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, alu_op 0, alu_a 0, alu_b 0, ops_done 0, reqN_ready 0.
- Request handshake at edge T:
  - Cycle T+1 is EXEC, with alu_* equal to the request.
  - rsp_valid goes high from cycle T+2.
- With rsp_ready tied high, rsp_valid is high for exactly one cycle (T+2). The FSM is back in IDLE at T+3, and the next accept is at the earliest at the end of T+3.
- Steady-state throughput is one operation per 3 cycles.
- Response back-pressure of k cycles adds k cycles. No request is accepted during RESP.
- Reset asserted in EXEC or RESP discards the operation: no response and no ops_done increment. Reset asserted in IDLE suppresses ready immediately.

## Test plan
- Single request: req0 MUL, a=-32, b=5, rsp_ready=1 → req0_ready in the first valid cycle; alu_* = {00111,-32,5} in the next cycle; then rsp_valid for 1 cycle with rsp_id=0, rsp_result=-160 (16'hFF60), rsp_flags = ALU flags; ops_done=1.
- Contention: both requesters valid continuously, req0 (-13 × -3), req1 (16 × 11), rsp_ready=1 → grants in order 0,1,0,1; results 39, 176, 39, 176; accepts exactly 3 cycles apart.
- Back-pressure: req1 MUL 16 × -10, rsp_ready low for 4 cycles → rsp_valid, rsp_id=1 and rsp_result=-160 are held stable for 4 cycles; no req0_ready during that time; release → IDLE on the next cycle.
- Withdrawn request: req0_valid pulses for one cycle while RESP is pending → no grant; no spurious response; ops_done unchanged.
- Reset mid-operation: assert rst during EXEC of 9 × 1 → all outputs immediately at reset values; no response after release; the first contention after release grants req0.
- Counter wrap: preload by running 65536 responses (or force ops_done=16'hFFFF) → the next handshake yields ops_done=0.
